// File: rtl/memory_sequencer.sv
// Pattern-memory playback sequencer: walks first..last, one read per frame period.
// Optional MEMSEQ_PAUSE_EN adds pause_i, which freezes the frame timer in HOLD.
module memory_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2,
  parameter int TICK_DIV   = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
`ifdef MEMSEQ_PAUSE_EN
  input  logic              pause_i,
`endif
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rden_o,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic [DATA_W-1:0] pattern_o,
  output logic              pattern_valid_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] RD_TICK   = TW'(RD_LATENCY);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, first_q, first_d, last_q, last_d;
  logic [DATA_W-1:0]   pattern_q, pattern_d;
  logic                rden_q, rden_d, pvld_q, pvld_d, done_q, done_d;
  logic                paused;

`ifdef MEMSEQ_PAUSE_EN
  assign paused = pause_i;
`else
  assign paused = 1'b0;
`endif

  // tick_q counts cycles since the last FETCH, so one frame is FETCH..LAST_TICK.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    addr_d    = addr_q;
    first_d   = first_q;
    last_d    = last_q;
    pattern_d = pattern_q;
    rden_d    = 1'b0;
    pvld_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (start_i && !stop_i) begin
        first_d = first_addr_i;
        last_d  = last_addr_i;
        addr_d  = first_addr_i;
        rden_d  = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        tick_d  = TW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        tick_d = tick_q + TW'(1);
        if (tick_q == RD_TICK) begin
          pattern_d = mem_q_i;
          pvld_d    = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: if (!paused) begin
        tick_d = tick_q + TW'(1);
        if (tick_q == LAST_TICK) begin
          if (addr_q != last_q) begin
            addr_d  = addr_q + ADDR_W'(1);
            rden_d  = 1'b1;
            state_d = FETCH;
          end else if (loop_i) begin
            addr_d  = first_q;
            rden_d  = 1'b1;
            state_d = FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort discards any in-flight read and leaves the displayed frame alone.
    if (stop_i && state_q != IDLE) begin
      state_d   = IDLE;
      addr_d    = addr_q;
      pattern_d = pattern_q;
      rden_d    = 1'b0;
      pvld_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      addr_q    <= '0;
      first_q   <= '0;
      last_q    <= '0;
      pattern_q <= '0;
      rden_q    <= 1'b0;
      pvld_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      addr_q    <= addr_d;
      first_q   <= first_d;
      last_q    <= last_d;
      pattern_q <= pattern_d;
      rden_q    <= rden_d;
      pvld_q    <= pvld_d;
      done_q    <= done_d;
    end
  end

  assign mem_addr_o      = addr_q;
  assign mem_rden_o      = rden_q;
  assign pattern_o       = pattern_q;
  assign pattern_valid_o = pvld_q;
  assign done_o          = done_q;
  assign busy_o          = (state_q != IDLE);

endmodule
